decoder_encode8to3_seq: RTL and testbench

DECODER_ENCODE8TO3_SEQ -- requirements
Module: decoder_encode8to3_seq

---
 rtl/decoder_encode8to3_seq.sv | 118 +++++++++++
 tb/tb_decoder_encode8to3_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_encode8to3_seq.sv
// Sequential 8-to-3 priority encoder. It captures a line vector on start, then
// emits one index per accepted handshake until no lines remain set.
module decoder_encode8to3_seq #(
   parameter int HIGH_FIRST = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] d,
   input  logic       code_ready,
   output logic [2:0] code,
   output logic       code_valid,
   output logic       busy,
   output logic       done,
   output logic       none,
   output logic [3:0] count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] pend_reg, pend_next;
   logic [3:0] count_reg, count_next;
   logic       none_reg, none_next;

   logic [7:0] scan_vec;
   logic [2:0] scan_pos;
   logic [2:0] sel_idx;
   logic [7:0] pend_cleared;

   // Mirror the pending vector when scanning from the top, so a single
   // lowest-set-bit search serves both orders.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_order
         if (HIGH_FIRST != 0) begin : g_rev
            assign scan_vec[gi] = pend_reg[7-gi];
         end else begin : g_fwd
            assign scan_vec[gi] = pend_reg[gi];
         end
      end
   endgenerate

   always_comb begin
      scan_pos = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (scan_vec[i]) begin
            scan_pos = 3'(i);
         end
      end
   end

   assign sel_idx      = (HIGH_FIRST != 0) ? (3'd7 - scan_pos) : scan_pos;
   assign pend_cleared = pend_reg & ~(8'd1 << sel_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         pend_reg  <= 8'd0;
         count_reg <= 4'd0;
         none_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         pend_reg  <= pend_next;
         count_reg <= count_next;
         none_reg  <= none_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pend_next  = pend_reg;
      count_next = count_reg;
      none_next  = none_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               pend_next  = d;
               count_next = 4'd0;
               if (d == 8'd0) begin
                  none_next  = 1'b1;
                  state_next = DONE;
               end else begin
                  none_next  = 1'b0;
                  state_next = SCAN;
               end
            end
         end
         SCAN: begin
            if (code_ready) begin
               pend_next  = pend_cleared;
               count_next = count_reg + 4'd1;
               if (pend_cleared == 8'd0) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Every output comes from state or the registered pending vector only.
   assign code_valid = (state_reg == SCAN);
   assign code       = code_valid ? sel_idx : 3'd0;
   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == DONE);
   assign none       = none_reg;
   assign count      = count_reg;

endmodule

// File: tb/tb_decoder_encode8to3_seq.sv
// Scoreboard bench for both scan orders of decoder_encode8to3_seq, driven by
// directed and random line vectors with random consumer back-pressure.
module tb_decoder_encode8to3_seq;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] d;
   logic       code_ready;

   logic [2:0] code_lo, code_hi;
   logic       code_valid_lo, code_valid_hi;
   logic       busy_lo, busy_hi;
   logic       done_lo, done_hi;
   logic       none_lo, none_hi;
   logic [3:0] count_lo, count_hi;

   decoder_encode8to3_seq #(.HIGH_FIRST(0)) u_lo (
      .clk(clk), .rst(rst), .start(start), .d(d), .code_ready(code_ready),
      .code(code_lo), .code_valid(code_valid_lo), .busy(busy_lo),
      .done(done_lo), .none(none_lo), .count(count_lo)
   );

   decoder_encode8to3_seq #(.HIGH_FIRST(1)) u_hi (
      .clk(clk), .rst(rst), .start(start), .d(d), .code_ready(code_ready),
      .code(code_hi), .code_valid(code_valid_hi), .busy(busy_hi),
      .done(done_hi), .none(none_hi), .count(count_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [2:0] q_lo[$];
   logic [2:0] q_hi[$];
   logic [3:0] cnt_q[$];
   logic       none_q[$];

   task automatic chk(input logic ok, input string name,
                      input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference: lines in ascending or descending index order, count = popcount.
   task automatic push_expect(input logic [7:0] dv);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         if (dv[i]) begin
            q_lo.push_back(3'(i));
            ones++;
         end
         if (dv[7-i]) q_hi.push_back(3'(7 - i));
      end
      cnt_q.push_back(4'(ones));
      none_q.push_back(dv == 8'd0);
      $display("txn start d=0x%02h expect %0d codes", dv, ones);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   logic       prev_hold, prev_done, exp_first;
   logic [7:0] exp_first_d;
   logic [2:0] prev_code_lo, prev_code_hi;

   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
         prev_done = 1'b0;
         exp_first = 1'b0;
      end else begin
         if (exp_first) begin
            chk(code_valid_lo == (exp_first_d != 8'd0), "first_valid", code_valid_lo, exp_first_d != 8'd0);
            chk(done_lo == (exp_first_d == 8'd0), "first_done", done_lo, exp_first_d == 8'd0);
         end
         exp_first   = start && !busy_lo;
         exp_first_d = d;

         if (prev_hold)
            chk(code_valid_lo && code_lo == prev_code_lo && code_hi == prev_code_hi,
                "hold_stable", {code_valid_lo, code_lo, code_hi}, {1'b1, prev_code_lo, prev_code_hi});
         prev_hold    = code_valid_lo && !code_ready;
         prev_code_lo = code_lo;
         prev_code_hi = code_hi;

         chk(code_valid_lo == code_valid_hi, "valid_match", code_valid_hi, code_valid_lo);
         if (!code_valid_lo)
            chk(code_lo == 3'd0 && code_hi == 3'd0, "code_zero_idle", {code_lo, code_hi}, 0);

         if (code_valid_lo && code_ready) begin
            if (q_lo.size() == 0 || q_hi.size() == 0) begin
               chk(1'b0, "unexpected_code", code_lo, 0);
            end else begin
               logic [2:0] e_lo, e_hi;
               e_lo = q_lo.pop_front();
               e_hi = q_hi.pop_front();
               chk(code_lo == e_lo, "code_low_first", code_lo, e_lo);
               chk(code_hi == e_hi, "code_high_first", code_hi, e_hi);
               $display("txn code lo=%0d hi=%0d", code_lo, code_hi);
            end
         end

         if (prev_done)
            chk(!done_lo && !busy_lo && !done_hi && !busy_hi, "done_one_cycle",
                {done_lo, busy_lo, done_hi, busy_hi}, 0);
         if (done_lo) begin
            chk(busy_lo, "busy_in_done", busy_lo, 1);
            chk(q_lo.size() == 0, "codes_left", q_lo.size(), 0);
            if (cnt_q.size() == 0) begin
               chk(1'b0, "unexpected_done", done_lo, 0);
            end else begin
               logic [3:0] e_cnt;
               logic       e_none;
               e_cnt  = cnt_q.pop_front();
               e_none = none_q.pop_front();
               chk(count_lo == e_cnt && count_hi == e_cnt, "count_at_done", {count_lo, count_hi}, {e_cnt, e_cnt});
               chk(none_lo == e_none && none_hi == e_none, "none_at_done", {none_lo, none_hi}, {e_none, e_none});
               $display("txn done count=%0d none=%0d", count_lo, none_lo);
            end
         end
         prev_done = done_lo;
      end
   end

   // One scan: capture, then drive ready (after 'hold' stalled cycles) until done.
   task automatic issue(input logic [7:0] dv, input int pct, input int hold, input bit junk);
      int cyc;
      start = 1'b1;
      d     = dv;
      push_expect(dv);
      step();
      start = 1'b0;
      cyc   = 0;
      while (!done_lo && cyc < 200) begin
         code_ready = (cyc >= hold) && ($urandom_range(99, 0) < pct);
         if (junk) begin
            start = 1'($urandom_range(1, 0));
            d     = 8'($urandom);
         end
         step();
         cyc++;
      end
      chk(done_lo, "done_timeout", done_lo, 1);
      // A start in the DONE cycle must also be ignored.
      if (junk) begin
         start = 1'b1;
         d     = 8'($urandom);
      end
      step();
      start      = 1'b0;
      code_ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      d          = 8'd0;
      code_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk({code_lo, code_valid_lo, busy_lo, done_lo, none_lo, count_lo} == 11'd0 &&
          {code_hi, code_valid_hi, busy_hi, done_hi, none_hi, count_hi} == 11'd0,
          "reset_state", {code_lo, code_valid_lo, busy_lo, done_lo, none_lo, count_lo}, 0);
      rst = 1'b0;
      step();

      issue(8'hA4, 100, 0, 1'b0);
      issue(8'hFF, 100, 0, 1'b0);
      chk(count_lo == 4'd8 && !busy_lo, "count_hold_ff", {busy_lo, count_lo}, 8);
      issue(8'h10, 100, 4, 1'b0);
      issue(8'h00, 100, 0, 1'b0);
      chk(none_lo && none_hi, "none_hold", {none_lo, none_hi}, 3);
      issue(8'h01, 100, 0, 1'b0);
      chk(!none_lo && !none_hi && count_lo == 4'd1, "none_cleared", {none_lo, count_lo}, 1);
      issue(8'h5A, 60, 0, 1'b1);

      // Reset in mid-scan after two transfers: no done, all outputs drop at once.
      start      = 1'b1;
      d          = 8'hC3;
      code_ready = 1'b1;
      push_expect(8'hC3);
      step();
      start = 1'b0;
      step();
      step();
      rst = 1'b1;
      q_lo.delete();
      q_hi.delete();
      cnt_q.delete();
      none_q.delete();
      #1;
      chk({code_lo, code_valid_lo, busy_lo, done_lo, none_lo, count_lo} == 11'd0 &&
          {code_hi, code_valid_hi, busy_hi, done_hi, none_hi, count_hi} == 11'd0,
          "async_reset", {code_lo, code_valid_lo, busy_lo, done_lo, none_lo, count_lo}, 0);
      code_ready = 1'b0;
      step();
      rst = 1'b0;
      step();
      issue(8'h08, 100, 0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [7:0] dv;
         dv = ($urandom_range(4, 0) == 0) ? 8'd0 : 8'($urandom);
         issue(dv, $urandom_range(100, 20), $urandom_range(3, 0), 1'($urandom_range(1, 0)));
      end

      repeat (3) step();
      chk(q_lo.size() == 0 && cnt_q.size() == 0, "scoreboard_drained", q_lo.size() + cnt_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
